instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end for the 4-bit RISC core. It holds a 16-word × 4-bit program memory, loaded through a write port, and walks a fetch address through it. Fetched instructions are buffered in a small prefetch FIFO and presented to the core's 4-bit instruction input over a valid/ready handshake. Redirect, stop and end-of-program conditions are handled here so that the core sees only a clean instruction stream.

## Interface
Parameters:
- DEPTH, 4: prefetch FIFO depth; power of two, ≥ 2.
- WRAP, 1: 1 = fetch address wraps 15→0 and continues; 0 = stop after fetching address 15 (END state).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- load_en  in  1  program memory write strobe.
- load_addr  in  4  write address.
- load_data  in  4  write data.
- start  in  1  begin/resume fetching.
- stop  in  1  halt fetching; FIFO keeps draining.
- redirect  in  1  flush FIFO and jump.
- redirect_addr  in  4  new fetch address.
- instr  out  4  FIFO head instruction; 0 when instr_valid = 0.
- instr_pc  out  4  memory address of the head instruction; 0 when empty.
- instr_valid  out  1  head entry is valid.
- instr_ready  in  1  core accepts head.
- level  out  log2(DEPTH)+1  FIFO occupancy.
- busy  out  1  state is RUN.

## Operation
- Reset (reset_n = 0 at an edge) does the following:
  - state = IDLE, fetch_addr = 0, FIFO empty.
  - All 16 memory words are cleared to 0.
  - Outputs: instr = 0, instr_pc = 0, instr_valid = 0, level = 0, busy = 0.
  - Reset overrides every other input.
- States are IDLE, RUN and END.
  - IDLE: start → RUN.
  - RUN: stop → IDLE. If WRAP = 0 and address 15 is pushed, go to END.
  - END: start → RUN with fetch_addr = 0.
  - If stop and start are both asserted, stop wins (in IDLE, remain IDLE).
- Memory read is combinational: mem[fetch_addr].
- A push happens at an edge when all of these hold:
  - state = RUN,
  - no redirect,
  - (level < DEPTH) or a pop occurs at the same edge.
- On a push:
  - The entry {mem[fetch_addr], fetch_addr} is written to the FIFO tail.
  - fetch_addr increments modulo 16 (15 → 0).
  - With WRAP = 0, fetch_addr is left at 15 and the state goes to END.
- A pop happens at an edge when instr_valid & instr_ready & !redirect.
- Push and pop at the same edge, including when the FIFO is full: level is unchanged.
- Redirect (any state) has priority over push and pop:
  - FIFO is flushed (level → 0).
  - fetch_addr ← redirect_addr.
  - State is unchanged, except END → IDLE.
  - A handshake in the redirect cycle is discarded: it does not count as a transfer.
- Load port: mem[load_addr] ← load_data at the edge when load_en = 1, in any state.
  - If the same address is fetched at that edge, the fetch reads the old data (read-before-write).
  - FIFO entries already fetched are never updated by a load.
- start in RUN and stop in IDLE/END have no effect.
- instr, instr_pc and instr_valid are driven directly from the FIFO head; they are stable while instr_valid = 1 and instr_ready = 0.

## Timing
- With start sampled at edge E (state IDLE, FIFO empty):
  - busy = 1 after E.
  - First push at E+1; instr_valid = 1 after E+1.
  - Start-to-valid latency is 2 edges.
- Throughput is 1 instruction per cycle while ready is held high: a push and a pop every edge, level steady at 1.
- With instr_ready held low, the FIFO fills to DEPTH in DEPTH edges after RUN is entered; pushes then stall and fetch_addr holds.
- Redirect at edge R:
  - instr_valid = 0 after R.
  - mem[redirect_addr] is pushed at R+1 (if RUN); valid again after R+1.
- stop at edge S: no push at S or later. The FIFO continues popping until empty.
- reset_n low mid-operation: every output takes its reset value after that edge; no partial transfer.

## Test plan
- Reset, then load mem[0..3] = 1,2,3,4, then start with ready = 1 → instr_valid rises 2 edges after start; sequence 1,2,3,4 is seen on consecutive cycles with instr_pc 0,1,2,3.
- Ready = 0 after start, DEPTH = 4 → level reaches 4 and stays there; fetch_addr holds at 4. Raise ready → instructions at pc 0..3 drain in order, then pc 4 follows with no gap.
- Redirect to address 9 while the FIFO holds 3 entries, ready = 1 in the same cycle → level = 0 and instr_valid = 0 next cycle; that handshake is not a transfer; next instr_pc = 9, instr = mem[9].
- WRAP = 0, start at 0 with ready = 1 → 16 instructions (pc 0..15), state END, busy = 0, no further pushes. Start again → pc 0 is fetched again.
- WRAP = 1: fetch passes 15 → instr_pc sequence is 14, 15, 0, 1.
- Load mem[5] = A while fetch_addr = 5 pushes at the same edge → the FIFO entry holds the old value. After a redirect to 5, the fetch returns A.
- reset_n low for one cycle while level = 3 and busy = 1 → all outputs are 0 next cycle; a subsequent start fetches 0, as memory has been cleared.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: 16x4 program memory, fetch address walker and a
// prefetch FIFO presenting {instr, pc} to the core over a valid/ready handshake.
module instr_fetch_unit #(
    parameter int DEPTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_en,
    input  logic [3:0]               load_addr,
    input  logic [3:0]               load_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     redirect,
    input  logic [3:0]               redirect_addr,
    output logic [3:0]               instr,
    output logic [3:0]               instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic [1:0]               state_dbg
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      fetch_addr_q, fetch_addr_d;
    logic [3:0]      mem_q [16];
    logic [3:0]      mem_d [16];
    logic [7:0]      fifo_q [DEPTH];
    logic [7:0]      fifo_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     level_q, level_d;
    logic            push;
    logic            pop;

    // Handshake: a transfer happens at an edge where instr_valid and
    // instr_ready are both high and no redirect is flushing the FIFO.
    assign instr_valid = (level_q != '0);
    assign instr       = instr_valid ? fifo_q[rd_ptr_q][7:4] : 4'd0;
    assign instr_pc    = instr_valid ? fifo_q[rd_ptr_q][3:0] : 4'd0;
    assign level       = level_q;
    assign busy        = (state_q == ST_RUN);
    assign state_dbg   = state_q;

    assign pop  = instr_valid && instr_ready && !redirect;
    assign push = (state_q == ST_RUN) && !redirect && !stop &&
                  ((level_q < FULL_LVL) || pop);

    // Registered memory gives read-before-write against a same-edge load.
    always_comb begin
        mem_d = mem_q;
        if (load_en) mem_d[load_addr] = load_data;
    end

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        if (redirect) begin
            level_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fetch_addr_d = redirect_addr;
            if (state_q == ST_END) state_d = ST_IDLE;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = {mem_q[fetch_addr_q], fetch_addr_q};
                wr_ptr_d         = wr_ptr_q + 1'b1;
                if (!WRAP && (fetch_addr_q == 4'd15)) fetch_addr_d = 4'd15;
                else                                  fetch_addr_d = fetch_addr_q + 4'd1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            case (state_q)
                ST_IDLE: if (start && !stop) state_d = ST_RUN;
                ST_RUN: begin
                    if (stop) state_d = ST_IDLE;
                    else if (push && !WRAP && (fetch_addr_q == 4'd15)) state_d = ST_END;
                end
                ST_END: begin
                    if (start && !stop) begin
                        state_d      = ST_RUN;
                        fetch_addr_d = 4'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= 4'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            for (int i = 0; i < 16; i++) mem_q[i] <= 4'd0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 8'd0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            mem_q        <= mem_d;
            fifo_q       <= fifo_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a WRAP=1 instance and a WRAP=0 instance, each with
// an expected {instr, pc} queue drained by a monitor on every accepted transfer.
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset_n;
  logic       load_en, start, stop, redirect, instr_ready;
  logic [3:0] load_addr, load_data, redirect_addr;
  logic [3:0] instr, instr_pc;
  logic       instr_valid, busy;
  logic [2:0] level;
  logic [1:0] state_dbg;

  logic       w0_load_en, w0_start, w0_stop, w0_redirect, w0_ready;
  logic [3:0] w0_load_addr, w0_load_data, w0_redirect_addr;
  logic [3:0] w0_instr, w0_pc;
  logic       w0_valid, w0_busy;
  logic [2:0] w0_level;
  logic [1:0] w0_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp0_q[$];
  logic [3:0] bmem[16];
  logic [3:0] b0mem[16];

  instr_fetch_unit #(.DEPTH(4), .WRAP(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stop(stop), .redirect(redirect),
    .redirect_addr(redirect_addr), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .level(level),
    .busy(busy), .state_dbg(state_dbg)
  );

  instr_fetch_unit #(.DEPTH(4), .WRAP(1'b0)) dut_w0 (
    .clk(clk), .reset_n(reset_n), .load_en(w0_load_en), .load_addr(w0_load_addr),
    .load_data(w0_load_data), .start(w0_start), .stop(w0_stop), .redirect(w0_redirect),
    .redirect_addr(w0_redirect_addr), .instr(w0_instr), .instr_pc(w0_pc),
    .instr_valid(w0_valid), .instr_ready(w0_ready), .level(w0_level),
    .busy(w0_busy), .state_dbg(w0_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic load(input logic [3:0] a, input logic [3:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    bmem[a] = d;
  endtask

  task automatic redir(input logic [3:0] a);
    redirect = 1'b1; redirect_addr = a;
    tick();
    redirect = 1'b0;
  endtask

  task automatic expect_pc(input logic [3:0] pc);
    exp_q.push_back({bmem[pc], pc});
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (reset_n && instr_valid && instr_ready && !redirect) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got instr=%0h pc=%0d with empty queue", instr, instr_pc);
      end else begin
        e = exp_q.pop_front();
        if ({instr, instr_pc} !== e) begin
          errors++;
          $display("FAIL xfer: got instr=%0h pc=%0d expected instr=%0h pc=%0d",
                   instr, instr_pc, e[7:4], e[3:0]);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_w0
    logic [7:0] e;
    if (reset_n && w0_valid && w0_ready && !w0_redirect) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL w0_xfer_unexpected: got instr=%0h pc=%0d with empty queue", w0_instr, w0_pc);
      end else begin
        e = exp0_q.pop_front();
        if ({w0_instr, w0_pc} !== e) begin
          errors++;
          $display("FAIL w0_xfer: got instr=%0h pc=%0d expected instr=%0h pc=%0d",
                   w0_instr, w0_pc, e[7:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    load_en = 0; start = 0; stop = 0; redirect = 0; instr_ready = 0;
    load_addr = 0; load_data = 0; redirect_addr = 0;
    w0_load_en = 0; w0_start = 0; w0_stop = 0; w0_redirect = 0; w0_ready = 0;
    w0_load_addr = 0; w0_load_data = 0; w0_redirect_addr = 0;
    for (int i = 0; i < 16; i++) begin bmem[i] = 4'd0; b0mem[i] = 4'd0; end
    tick(); tick();
    reset_n = 1'b1;

    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, 0);

    // program: mem[i] = i+1 (mod 16)
    for (int i = 0; i < 16; i++) load(4'(i), 4'(i + 1));

    // basic stream, ready high
    for (int i = 0; i < 4; i++) expect_pc(4'(i));
    instr_ready = 1'b1;
    do_start();
    chk("start_busy", busy, 1);
    chk("start_valid_e", instr_valid, 0);
    tick();
    chk("start_valid_e1", instr_valid, 1);
    chk("first_instr", instr, 4'h1);
    chk("first_pc", instr_pc, 0);
    chk("steady_level", level, 1);
    tick(); tick(); tick();
    do_stop();
    chk("stop_level", level, 0);
    chk("stop_busy", busy, 0);

    // fill with ready low, then drain
    redir(4'd0);
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_pc(4'(i));
    do_start();
    repeat (5) tick();
    chk("full_level", level, 4);
    chk("full_head_pc", instr_pc, 0);
    chk("full_busy", busy, 1);
    instr_ready = 1'b1;
    tick();
    do_stop();
    chk("drain_valid", instr_valid, 1);
    tick(); tick(); tick();
    chk("drain_level", level, 0);

    // redirect with 3 entries and a same-cycle handshake
    redir(4'd0);
    instr_ready = 1'b0;
    do_start();
    repeat (3) tick();
    chk("pre_redir_level", level, 3);
    expect_pc(4'd9);
    expect_pc(4'd10);
    instr_ready = 1'b1;
    redir(4'd9);
    chk("redir_level", level, 0);
    chk("redir_valid", instr_valid, 0);
    chk("redir_busy", busy, 1);
    tick();
    chk("redir_pc", instr_pc, 9);
    chk("redir_instr", instr, 4'hA);
    tick();
    do_stop();
    chk("redir_end_level", level, 0);

    // wrap 15 -> 0
    redir(4'd14);
    for (int i = 0; i < 4; i++) expect_pc(4'(14 + i));
    do_start();
    repeat (4) tick();
    do_stop();
    chk("wrap_end_level", level, 0);

    // load during fetch of the same address: old data fetched
    redir(4'd5);
    instr_ready = 1'b0;
    expect_pc(4'd5);
    do_start();
    load_en = 1'b1; load_addr = 4'd5; load_data = 4'hA;
    tick();
    load_en = 1'b0;
    bmem[5] = 4'hA;
    do_stop();
    chk("rbw_level", level, 1);
    chk("rbw_old_instr", instr, 4'h6);
    instr_ready = 1'b1;
    tick();
    chk("rbw_pop_level", level, 0);
    redir(4'd5);
    expect_pc(4'd5);
    do_start();
    tick();
    chk("rbw_new_instr", instr, 4'hA);
    do_stop();
    chk("rbw_end_level", level, 0);

    // reset mid-operation
    redir(4'd0);
    instr_ready = 1'b0;
    do_start();
    repeat (3) tick();
    chk("prerst_level", level, 3);
    chk("prerst_busy", busy, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin bmem[i] = 4'd0; b0mem[i] = 4'd0; end
    chk("midrst_instr", instr, 0);
    chk("midrst_pc", instr_pc, 0);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_busy", busy, 0);
    instr_ready = 1'b1;
    expect_pc(4'd0);
    do_start();
    tick();
    chk("postrst_valid", instr_valid, 1);
    chk("postrst_instr", instr, 0);
    do_stop();

    // WRAP=0 instance: mem[i] = 15-i, run to END, restart
    w0_load_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w0_load_addr = 4'(i); w0_load_data = 4'(15 - i);
      tick();
      b0mem[i] = 4'(15 - i);
    end
    w0_load_en = 1'b0;
    for (int i = 0; i < 16; i++) exp0_q.push_back({b0mem[i], 4'(i)});
    w0_ready = 1'b1;
    w0_start = 1'b1;
    tick();
    w0_start = 1'b0;
    repeat (16) tick();
    chk("w0_end_busy", w0_busy, 0);
    chk("w0_end_state", w0_state, 2);
    chk("w0_end_level", w0_level, 1);
    repeat (3) tick();
    chk("w0_no_push_level", w0_level, 0);
    chk("w0_no_push_valid", w0_valid, 0);
    exp0_q.push_back({b0mem[0], 4'd0});
    w0_start = 1'b1;
    tick();
    w0_start = 1'b0;
    chk("w0_restart_busy", w0_busy, 1);
    tick();
    chk("w0_restart_pc", w0_pc, 0);
    chk("w0_restart_instr", w0_instr, 4'hF);
    w0_stop = 1'b1;
    tick();
    w0_stop = 1'b0;
    tick();

    chk("queue_drained", exp_q.size(), 0);
    chk("w0_queue_drained", exp0_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
